// File: rtl/seq_udp_lut.sv
// Runtime-programmable Mealy machine: a {state, inputs} -> {next_state, outputs}
// table loaded over a valid/ready port, stepped one entry per run cycle.
module seq_udp_lut #(
  parameter int              IN_W       = 3,
  parameter int              OUT_W      = 3,
  parameter int              ST_W       = 2,
  parameter logic [ST_W-1:0] INIT_STATE = '0
) (
  input  logic                   clock,
  input  logic                   reset_b,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [ST_W+IN_W-1:0]   load_addr,
  input  logic [ST_W+OUT_W-1:0]  load_data,
  input  logic                   run,
  input  logic                   clr,
  input  logic [IN_W-1:0]        in_bits,
  output logic [OUT_W-1:0]       out_bits,
  output logic                   out_valid,
  output logic [ST_W-1:0]        state,
  output logic                   table_full
);

  localparam int AW    = ST_W + IN_W;
  localparam int DW    = ST_W + OUT_W;
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    table_q [DEPTH];
  logic [DEPTH-1:0] written_q;
  logic [DW-1:0]    entry;
  logic             load_fire;

  // Stepping and clearing own the cycle, so loads are refused while either is active.
  assign load_ready = reset_b && !run && !clr;
  assign load_fire  = load_valid && load_ready;
  assign entry      = table_q[{state, in_bits}];

  // NOTE: the table is a register array that must read as all-zero after reset,
  // so every entry is explicitly cleared in the reset branch.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
      written_q  <= '0;
      table_full <= 1'b0;
    end else begin
      if (load_fire) begin
        table_q[load_addr]   <= load_data;
        written_q[load_addr] <= 1'b1;
      end
      // Registered from the bitmap, so it trails the final new write by one cycle.
      table_full <= &written_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state     <= INIT_STATE;
      out_bits  <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      state     <= INIT_STATE;
      out_valid <= 1'b0;
    end else if (run) begin
      state     <= entry[DW-1:OUT_W];
      out_bits  <= entry[OUT_W-1:0];
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule
